// File: rtl/conv_rgb_sequencer.sv
// Sequences one RGB image through three per-channel convolution engines and streams R+G+B dotproduct sums.
// Optional CONV_SEQ_RELU_EN clamps negative sums to zero before they are registered.
module conv_rgb_sequencer #(
   parameter int bitwidth    = 8,
   parameter int filterWidth = 3,
   parameter int imageWidth  = 11,
   parameter int numPixels   = imageWidth * imageWidth,
   parameter int numResults  = (imageWidth - filterWidth + 1) * (imageWidth - filterWidth + 1)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          mem_rd_en,
   output logic [$clog2(numPixels)-1:0]  mem_addr,
   input  logic [3*bitwidth-1:0]         mem_data,
   input  logic [3*bitwidth-1:0]         mem_filter,
   output logic                          conv_valid,
   output logic [3*bitwidth-1:0]         conv_data,
   output logic [3*bitwidth-1:0]         conv_filter,
   input  logic [2:0]                    dp_ready,
   input  logic [31:0]                   dp_r,
   input  logic [31:0]                   dp_g,
   input  logic [31:0]                   dp_b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [33:0]                   out_sum,
   output logic                          overflow
);

   localparam int AW = $clog2(numPixels);
   localparam int CW = $clog2(numResults + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [AW-1:0]    r_addr;
   logic             r_convValid;
   logic [CW-1:0]    r_count;
   logic [2:0][31:0] r_hold;
   logic [2:0]       r_full;
   logic             r_overflow;
   logic             r_outValid;
   logic [33:0]      r_outSum;

   logic             w_stall;
   logic             w_rdEn;
   logic             w_accept;
   logic             w_lastAddr;
   logic             w_launch;
   logic             w_transfer;
   logic [2:0][31:0] w_dp;
   logic [33:0]      w_sum;
   logic [33:0]      w_sumOut;

   assign w_stall    = r_outValid & ~out_ready;
   assign w_accept   = (r_state == IDLE) & start;
   assign w_lastAddr = (r_addr == AW'(numPixels - 1));
   assign w_launch   = (&r_full) & (~r_outValid | out_ready);
   assign w_transfer = r_outValid & out_ready;
   assign w_dp       = {dp_r, dp_g, dp_b};

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_rdEn      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE:  if (start) w_nextState = FETCH;
         FETCH: begin
            busy   = 1'b1;
            w_rdEn = ~w_stall;
            if (w_rdEn && w_lastAddr) w_nextState = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (r_count >= CW'(numResults)) w_nextState = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // The address returns to zero after the last pixel so the next run starts clean.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr      <= '0;
         r_convValid <= 1'b0;
      end else begin
         r_convValid <= w_rdEn;
         if (w_accept)    r_addr <= '0;
         else if (w_rdEn) r_addr <= w_lastAddr ? '0 : r_addr + AW'(1);
      end
   end

   // A slot freed by a launch can take a new dotproduct in that same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_hold     <= '0;
         r_full     <= '0;
         r_overflow <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (dp_ready[i] && (!r_full[i] || w_launch)) begin
               r_hold[i] <= w_dp[i];
               r_full[i] <= 1'b1;
            end else if (dp_ready[i]) begin
               r_overflow <= 1'b1;
            end else if (w_launch) begin
               r_full[i] <= 1'b0;
            end
         end
      end
   end

   assign w_sum = {{2{r_hold[2][31]}}, r_hold[2]}
                + {{2{r_hold[1][31]}}, r_hold[1]}
                + {{2{r_hold[0][31]}}, r_hold[0]};

`ifdef CONV_SEQ_RELU_EN
   assign w_sumOut = w_sum[33] ? '0 : w_sum;
`else
   assign w_sumOut = w_sum;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_outValid <= 1'b0;
         r_outSum   <= '0;
      end else if (w_launch) begin
         r_outValid <= 1'b1;
         r_outSum   <= w_sumOut;
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   // Saturating so surplus transfers in DRAIN cannot wrap the count.
   always_ff @(posedge clock) begin
      if (reset)                                       r_count <= '0;
      else if (w_accept)                               r_count <= '0;
      else if (w_transfer && r_count < CW'(numResults)) r_count <= r_count + CW'(1);
   end

   assign mem_rd_en   = w_rdEn;
   assign mem_addr    = r_addr;
   assign conv_valid  = r_convValid;
   assign conv_data   = r_convValid ? mem_data : '0;
   assign conv_filter = r_convValid ? mem_filter : '0;
   assign out_valid   = r_outValid;
   assign out_sum     = r_outSum;
   assign overflow    = r_overflow;

endmodule
